sdram_burst_dma_writer: RTL and testbench

//  Multi-channel stream-to-SDRAM DMA writer for the line-scanner datapath; sits between line capture and the HPS f2sdram Avalon-MM port.

---
 rtl/sdram_burst_dma_writer_if.sv | 15 +
 rtl/sdram_burst_dma_writer.sv | 149 ++++++++++++++
 tb/tb_sdram_burst_dma_writer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_burst_dma_writer_if.sv
// sdram_burst_dma_writer_if: Avalon-MM burst write bus between the DMA writer and the SDRAM port
interface sdram_burst_dma_writer_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 28,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0] address;
  logic [BURST_W-1:0] burstcount;
  logic write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic waitrequest;
  modport master(output address, burstcount, write, writedata, byteenable, input waitrequest);
  modport slave(input address, burstcount, write, writedata, byteenable, output waitrequest);
endinterface

// File: rtl/sdram_burst_dma_writer.sv
// sdram_burst_dma_writer: multi-channel stream-to-SDRAM circular-buffer burst writer; define DMA_IRQ_HALF_EN for a half-buffer irq.
module sdram_burst_dma_writer #(
  parameter int NCH = 2,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 28,
  parameter int BURST_W = 8,
  parameter int BURST_LEN = 16,
  parameter int FIFO_DEPTH = 64
)(
  input  logic clk,
  input  logic rst,
  input  logic [NCH*DATA_W-1:0] s_data,
  input  logic [NCH-1:0] s_valid,
  output logic [NCH-1:0] s_ready,
  input  logic [NCH*32-1:0] cfg_base,
  input  logic [NCH*32-1:0] cfg_size,
  input  logic [NCH-1:0] cfg_start,
  input  logic [NCH-1:0] cfg_stop,
  output logic [NCH-1:0] st_active,
  output logic [NCH*32-1:0] st_wr_off,
  output logic [NCH*16-1:0] st_wraps,
  output logic [NCH-1:0] st_overflow,
  output logic [NCH-1:0] irq,
  sdram_burst_dma_writer_if.master avm
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int BCW = $clog2(BURST_LEN) + 1;
  localparam int BSH = $clog2(DATA_W/8);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN*DATA_W/8);
  typedef enum logic [1:0] {IDLE, BURST, UPDATE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [NCH][FIFO_DEPTH];
  logic [PW-1:0] wp [NCH];
  logic [PW-1:0] rp [NCH];
  logic [PW:0] cnt [NCH];
  logic [31:0] base [NCH];
  logic [31:0] size [NCH];
  logic [31:0] off [NCH];
  logic [15:0] wraps [NCH];
  logic [NCH-1:0] push, pop, elig, start_ok;
  logic [SW-1:0] sel, rr, pick;
  logic found, accept;
  logic [BCW-1:0] beat;
  logic [31:0] off_n;
  assign accept = avm.write && !avm.waitrequest;
  assign avm.burstcount = avm.write ? BURST_W'(BURST_LEN) : '0;
  assign avm.byteenable = {(DATA_W/8){avm.write}};
  assign off_n = off[sel] + BURST_BYTES;
  for (genvar i = 0; i < NCH; i++) begin : g_st
    assign st_wr_off[i*32 +: 32] = off[i];
    assign st_wraps[i*16 +: 16] = wraps[i];
  end
  // a start on the channel currently being bursted is refused so its FIFO and offset stay coherent
  always_comb begin
    found = 1'b0;
    pick = rr;
    for (int k = 0; k < NCH; k++) begin
      s_ready[k] = st_active[k] && cnt[k] != (PW+1)'(FIFO_DEPTH);
      push[k] = s_valid[k] && s_ready[k];
      pop[k] = accept && sel == SW'(k);
      elig[k] = st_active[k] && cnt[k] >= (PW+1)'(BURST_LEN);
      start_ok[k] = cfg_start[k] && !cfg_stop[k] && !st_active[k] && cfg_size[k*32 +: 32] != 32'd0 && !(state != IDLE && sel == SW'(k));
    end
    for (int k = 0; k < NCH; k++) begin
      if (!found && elig[(int'(rr) + k) % NCH]) begin
        found = 1'b1;
        pick = SW'((int'(rr) + k) % NCH);
      end
    end
  end
  always_ff @(posedge clk)
    for (int k = 0; k < NCH; k++)
      if (push[k]) mem[k][wp[k]] <= s_data[k*DATA_W +: DATA_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      rr <= '0;
      beat <= '0;
      avm.write <= 1'b0;
      avm.address <= '0;
      avm.writedata <= '0;
      st_active <= '0;
      st_overflow <= '0;
      irq <= '0;
      for (int k = 0; k < NCH; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
        cnt[k] <= '0;
        base[k] <= '0;
        size[k] <= '0;
        off[k] <= '0;
        wraps[k] <= '0;
      end
    end else begin
      irq <= '0;
      for (int k = 0; k < NCH; k++) begin
        if (push[k] != pop[k]) cnt[k] <= push[k] ? cnt[k] + 1'b1 : cnt[k] - 1'b1;
        if (push[k]) wp[k] <= wp[k] + 1'b1;
        if (pop[k]) rp[k] <= rp[k] + 1'b1;
        if (st_active[k] && s_valid[k] && !s_ready[k]) st_overflow[k] <= 1'b1;
        if (cfg_stop[k]) st_active[k] <= 1'b0;
        if (start_ok[k]) begin
          base[k] <= cfg_base[k*32 +: 32];
          size[k] <= cfg_size[k*32 +: 32];
          off[k] <= '0;
          wraps[k] <= '0;
          st_overflow[k] <= 1'b0;
          wp[k] <= '0;
          rp[k] <= '0;
          cnt[k] <= '0;
          st_active[k] <= 1'b1;
        end
      end
      case (state)
        IDLE: if (found) begin
          state <= BURST;
          sel <= pick;
          rr <= pick == SW'(NCH-1) ? '0 : pick + 1'b1;
          beat <= '0;
          avm.write <= 1'b1;
          avm.address <= ADDR_W'((base[pick] + off[pick]) >> BSH);
          avm.writedata <= mem[pick][rp[pick]];
        end
        BURST: if (accept) begin
          beat <= beat + 1'b1;
          avm.writedata <= mem[sel][rp[sel] + 1'b1];
          if (beat == BCW'(BURST_LEN-1)) begin
            avm.write <= 1'b0;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          state <= IDLE;
          off[sel] <= off_n == size[sel] ? '0 : off_n;
          if (off_n == size[sel]) begin
            wraps[sel] <= wraps[sel] + 1'b1;
            irq[sel] <= 1'b1;
          end
`ifdef DMA_IRQ_HALF_EN
          if (off_n == size[sel] >> 1) irq[sel] <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_burst_dma_writer.sv
// tb_sdram_burst_dma_writer: directed table-driven bench for the DMA writer with a beat scoreboard.
module tb_sdram_burst_dma_writer;
  localparam int NCH = 2;
  localparam int DW = 128;
`ifdef DMA_IRQ_HALF_EN
  localparam int HALF = 1;
`else
  localparam int HALF = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH*DW-1:0] s_data = '0;
  logic [NCH-1:0] s_valid = '0;
  logic [NCH-1:0] cfg_start = '0;
  logic [NCH-1:0] cfg_stop = '0;
  logic [NCH*32-1:0] cfg_base = '0;
  logic [NCH*32-1:0] cfg_size = '0;
  logic [NCH-1:0] s_ready, st_active, st_overflow, irq;
  logic [NCH*32-1:0] st_wr_off;
  logic [NCH*16-1:0] st_wraps;
  sdram_burst_dma_writer_if #(.DATA_W(DW), .ADDR_W(28), .BURST_W(8)) avm ();
  sdram_burst_dma_writer #(.NCH(NCH), .DATA_W(DW), .ADDR_W(28), .BURST_W(8), .BURST_LEN(16), .FIFO_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_base(cfg_base), .cfg_size(cfg_size), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .st_active(st_active), .st_wr_off(st_wr_off), .st_wraps(st_wraps), .st_overflow(st_overflow),
    .irq(irq), .avm(avm)
  );
  always #5 clk = ~clk;
  typedef struct {
    int n;
    bit rnd;
    logic [27:0] addr;
    logic [31:0] off;
    logic [15:0] wraps;
    int irq_w;
    int irq_h;
  } vec_t;
  vec_t v [4];
  int checks = 0;
  int failures = 0;
  int bursts = 0;
  int beats = 0;
  int gcnt = 0;
  int grants [32];
  int irq_cnt [NCH] = '{0, 0};
  bit wr_rand = 1'b0;
  bit wr_force = 1'b0;
  bit in_burst = 1'b0;
  int b_ch = 0;
  logic [27:0] b_addr;
  logic [7:0] b_cnt;
  logic [27:0] last_addr [NCH];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] exp_w;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #2;
    avm.waitrequest = wr_force | (wr_rand & 1'($urandom_range(0, 1)));
  end
  always @(negedge clk) if (!rst) begin
    for (int c = 0; c < NCH; c++) irq_cnt[c] += int'(irq[c]);
    if (avm.write) begin
      if (!in_burst) begin
        in_burst = 1'b1;
        b_addr = avm.address;
        b_cnt = avm.burstcount;
        beats = 0;
        b_ch = avm.address >= 28'h200 ? 1 : 0;
        grants[gcnt % 32] = b_ch;
        gcnt++;
        chk("burstcount", 128'(avm.burstcount), 128'd16);
        chk("byteenable", 128'(avm.byteenable), 128'hFFFF);
      end else chk("addr_stable", 128'({avm.address, avm.burstcount}), 128'({b_addr, b_cnt}));
      if (!avm.waitrequest) begin
        if (b_ch == 1 && q1.size() > 0) exp_w = q1.pop_front();
        else if (b_ch == 0 && q0.size() > 0) exp_w = q0.pop_front();
        else exp_w = 'x;
        chk("beat_data", avm.writedata, exp_w);
        beats++;
        if (beats == 16) begin
          in_burst = 1'b0;
          bursts++;
          last_addr[b_ch] = b_addr;
        end
      end
    end else if (in_burst) begin
      chk("burst_short", 128'(beats), 128'd16);
      in_burst = 1'b0;
    end
  end
  task automatic push(input logic [1:0] m, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) if (m[c]) begin
        w = {$urandom, $urandom, $urandom, $urandom};
        s_data[c*DW +: DW] = w;
        if (c == 0) q0.push_back(w);
        else q1.push_back(w);
      end
      s_valid = m;
    end
    @(negedge clk);
    s_valid = '0;
  endtask
  task automatic start(input int c, input logic [31:0] b, input logic [31:0] sz, input bit stop);
    @(negedge clk);
    cfg_base[c*32 +: 32] = b;
    cfg_size[c*32 +: 32] = sz;
    cfg_start[c] = 1'b1;
    cfg_stop[c] = stop;
    @(negedge clk);
    cfg_start = '0;
    cfg_stop = '0;
  endtask
  task automatic stop(input int c);
    @(negedge clk);
    cfg_stop[c] = 1'b1;
    @(negedge clk);
    cfg_stop = '0;
  endtask
  task automatic wait_bursts(input int target);
    int t = 0;
    while (bursts < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("burst_done", 128'(bursts), 128'(target));
    repeat (4) @(negedge clk);
  endtask
  initial begin
    v[0] = '{16, 1'b0, 28'h100, 32'h100, 16'd0, 0, 1};
    v[1] = '{16, 1'b0, 28'h110, 32'h000, 16'd1, 1, 1};
    v[2] = '{16, 1'b1, 28'h100, 32'h100, 16'd1, 1, 2};
    v[3] = '{16, 1'b1, 28'h110, 32'h000, 16'd2, 2, 2};
    s_valid = '1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 128'(s_ready), 128'd0);
    chk("rst_active", 128'(st_active), 128'd0);
    chk("rst_wr_off", 128'(st_wr_off), 128'd0);
    chk("rst_wraps", 128'(st_wraps), 128'd0);
    chk("rst_overflow", 128'(st_overflow), 128'd0);
    chk("rst_irq", 128'(irq), 128'd0);
    chk("rst_write", 128'(avm.write), 128'd0);
    chk("rst_address", 128'(avm.address), 128'd0);
    chk("rst_burstcount", 128'(avm.burstcount), 128'd0);
    chk("rst_byteenable", 128'(avm.byteenable), 128'd0);
    chk("rst_writedata", avm.writedata, 128'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("inactive_ready", 128'(s_ready), 128'd0);
    chk("inactive_ovf", 128'(st_overflow), 128'd0);
    s_valid = '0;
    start(1, 32'h2000, 32'h0, 1'b0);
    chk("size0_ignored", 128'(st_active[1]), 128'd0);
    start(0, 32'h1000, 32'h200, 1'b0);
    chk("ch0_active", 128'(st_active[0]), 128'd1);
    chk("ch0_ready", 128'(s_ready[0]), 128'd1);
    for (int k = 0; k < 4; k++) begin
      wr_rand = v[k].rnd;
      push(2'b01, v[k].n);
      wait_bursts(k + 1);
      chk("vec_addr", 128'(last_addr[0]), 128'(v[k].addr));
      chk("vec_off", 128'(st_wr_off[31:0]), 128'(v[k].off));
      chk("vec_wraps", 128'(st_wraps[15:0]), 128'(v[k].wraps));
      chk("vec_irq", 128'(irq_cnt[0]), 128'(v[k].irq_w + HALF * v[k].irq_h));
      chk("vec_drained", 128'(q0.size()), 128'd0);
    end
    wr_rand = 1'b0;
    start(1, 32'h2000, 32'h400, 1'b1);
    chk("start_stop_wins", 128'(st_active[1]), 128'd0);
    start(1, 32'h2000, 32'h400, 1'b0);
    chk("ch1_active", 128'(st_active[1]), 128'd1);
    push(2'b11, 32);
    wait_bursts(8);
    for (int k = 0; k < 4; k++) chk("rr_order", 128'(grants[4 + k]), 128'(k % 2 == 0 ? 1 : 0));
    chk("t5_addr0", 128'(last_addr[0]), 128'h110);
    chk("t5_addr1", 128'(last_addr[1]), 128'h210);
    chk("t5_off1", 128'(st_wr_off[63:32]), 128'h200);
    chk("t5_wraps1", 128'(st_wraps[31:16]), 128'd0);
    chk("t5_wraps0", 128'(st_wraps[15:0]), 128'd3);
    chk("t5_irq0", 128'(irq_cnt[0]), 128'(3 + 3 * HALF));
    chk("t5_irq1", 128'(irq_cnt[1]), 128'(HALF));
    chk("t5_drained", 128'(q0.size() + q1.size()), 128'd0);
    stop(1);
    chk("ch1_stopped", 128'(st_active[1]), 128'd0);
    chk("ch1_not_ready", 128'(s_ready[1]), 128'd0);
    wr_force = 1'b1;
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      chk("t6_ready", 128'(s_ready[0]), 128'(i < 64));
      if (i == 64) chk("t6_no_ovf_yet", 128'(st_overflow[0]), 128'd0);
      exp_w = {$urandom, $urandom, $urandom, $urandom};
      if (i < 64) q0.push_back(exp_w);
      s_data[DW-1:0] = exp_w;
      s_valid = 2'b01;
    end
    @(negedge clk);
    s_valid = '0;
    chk("t6_ovf", 128'(st_overflow[0]), 128'd1);
    repeat (5) @(negedge clk);
    chk("t6_ovf_sticky", 128'(st_overflow[0]), 128'd1);
    wr_force = 1'b0;
    wait_bursts(12);
    chk("t6_drained", 128'(q0.size()), 128'd0);
    chk("t6_off", 128'(st_wr_off[31:0]), 128'd0);
    chk("t6_wraps", 128'(st_wraps[15:0]), 128'd5);
    chk("t6_irq0", 128'(irq_cnt[0]), 128'(5 + 5 * HALF));
    chk("t6_ovf_kept", 128'(st_overflow[0]), 128'd1);
    stop(0);
    chk("ch0_stopped", 128'(st_active[0]), 128'd0);
    chk("ovf_after_stop", 128'(st_overflow[0]), 128'd1);
    start(0, 32'h1000, 32'h200, 1'b0);
    chk("ovf_cleared", 128'(st_overflow[0]), 128'd0);
    chk("restart_wraps", 128'(st_wraps[15:0]), 128'd0);
    chk("restart_active", 128'(st_active[0]), 128'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
